// File: rtl/distribute_1xn_pipe.sv
// distribute_1xn_pipe
// Registered 1-to-N word distributor with per-lane valid/ready handshakes.
// One input word is captured into a single buffer together with a
// destination mask. Each targeted lane presents the word until its
// downstream consumer takes it. The lanes drain independently.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   i_en         intake enable; 0 blocks acceptance of new words
//   i_valid      input word valid
//   o_ready      a word can be accepted this cycle
//   i_data_bus   input word
//   i_cmd        destination mask; bit k targets lane k
//   o_valid      per-lane output valid
//   i_ready      per-lane downstream ready
//   o_data_bus   lane k occupies [k*DATA_WIDTH +: DATA_WIDTH]
//   o_stall_cnt  saturating count of cycles with i_valid & ~o_ready
//                (exists only when DISTRIBUTE_1XN_PIPE_STALL_CNT_EN is defined)
//
// Optional feature macro: DISTRIBUTE_1XN_PIPE_STALL_CNT_EN
module distribute_1xn_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_OUTPUT = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_en,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [DATA_WIDTH-1:0]            i_data_bus,
  input  logic [NUM_OUTPUT-1:0]            i_cmd,
  output logic [NUM_OUTPUT-1:0]            o_valid,
  input  logic [NUM_OUTPUT-1:0]            i_ready,
  output logic [NUM_OUTPUT*DATA_WIDTH-1:0] o_data_bus
`ifdef DISTRIBUTE_1XN_PIPE_STALL_CNT_EN
  ,
  output logic [15:0]                      o_stall_cnt
`endif
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [NUM_OUTPUT-1:0] pend_q, pend_d;
  logic                  accept;

  // A new word fits when every lane still owing the old word completes now.
  // The combinational path from i_ready is intentional for full throughput.
  assign o_ready = i_en & ~rst & ((pend_q & ~i_ready) == '0);
  assign accept  = i_valid & o_ready;

  always_comb begin
    data_d = data_q;
    pend_d = pend_q & ~i_ready;
    // Accept overrides drain: every old bit is being cleared on this edge anyway.
    if (accept) begin
      data_d = i_data_bus;
      pend_d = i_cmd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      pend_q <= '0;
    end else begin
      data_q <= data_d;
      pend_q <= pend_d;
    end
  end

  assign o_valid = pend_q;

  // Lanes that are not pending drive zeros, not stale data.
  for (genvar k = 0; k < NUM_OUTPUT; k++) begin : g_lane
    assign o_data_bus[k*DATA_WIDTH +: DATA_WIDTH] = pend_q[k] ? data_q : '0;
  end

`ifdef DISTRIBUTE_1XN_PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (i_valid && !o_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_distribute_1xn_pipe.sv
// Directed self-checking bench for distribute_1xn_pipe (DATA_WIDTH=32, NUM_OUTPUT=4).
module tb_distribute_1xn_pipe;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_en;
  logic         i_valid;
  logic         o_ready;
  logic [31:0]  i_data_bus;
  logic [3:0]   i_cmd;
  logic [3:0]   o_valid;
  logic [3:0]   i_ready;
  logic [127:0] o_data_bus;
`ifdef DISTRIBUTE_1XN_PIPE_STALL_CNT_EN
  logic [15:0]  o_stall_cnt;
  logic [15:0]  cnt_base;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  distribute_1xn_pipe #(
    .DATA_WIDTH(32),
    .NUM_OUTPUT(4)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .i_en       (i_en),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_data_bus (i_data_bus),
    .i_cmd      (i_cmd),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data_bus (o_data_bus)
`ifdef DISTRIBUTE_1XN_PIPE_STALL_CNT_EN
    ,
    .o_stall_cnt(o_stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    i_en       = 1'b1;
    i_valid    = 1'b0;
    i_data_bus = '0;
    i_cmd      = '0;
    i_ready    = '0;

    // 1. Reset / idle
    tick();
    check("rst_valid", {124'd0, o_valid}, 128'd0);
    check("rst_data", o_data_bus, 128'd0);
    check("rst_ready", {127'd0, o_ready}, 128'd0);
    tick();
    rst = 1'b0;
    #1;
    check("idle_ready", {127'd0, o_ready}, 128'd1);
    check("idle_valid", {124'd0, o_valid}, 128'd0);

    // 2. Unicast to lane 2
    i_valid    = 1'b1;
    i_cmd      = 4'b0100;
    i_data_bus = 32'hAAAAAAAA;
    i_ready    = 4'b1111;
    #1;
    check("uni_ready", {127'd0, o_ready}, 128'd1);
    tick();
    i_valid = 1'b0;
    check("uni_valid", {124'd0, o_valid}, 128'h4);
    check("uni_data", o_data_bus, 128'h00000000_AAAAAAAA_00000000_00000000);
    tick();
    check("uni_clear", {124'd0, o_valid}, 128'd0);

    // 3. Broadcast at full rate
    i_valid = 1'b1;
    i_cmd   = 4'b1111;
    for (int w = 1; w <= 3; w++) begin
      i_data_bus = 32'(w);
      #1;
      check("bc_ready", {127'd0, o_ready}, 128'd1);
      tick();
      check("bc_valid", {124'd0, o_valid}, 128'hF);
      check("bc_data", o_data_bus, {4{32'(w)}});
    end
    i_valid = 1'b0;
    tick();
    check("bc_clear", {124'd0, o_valid}, 128'd0);

    // 4. Partial backpressure: lanes 0 and 2 drain, 1 and 3 stall
    i_valid    = 1'b1;
    i_cmd      = 4'b1111;
    i_data_bus = 32'hBBBBBBBB;
    i_ready    = 4'b0101;
    tick();
    check("bp_valid0", {124'd0, o_valid}, 128'hF);
    i_cmd      = 4'b0011;
    i_data_bus = 32'hCCCCCCCC;
    #1;
    check("bp_ready0", {127'd0, o_ready}, 128'd0);
    tick();
    check("bp_valid1", {124'd0, o_valid}, 128'hA);
    check("bp_data1", o_data_bus, 128'hBBBBBBBB_00000000_BBBBBBBB_00000000);
    check("bp_ready1", {127'd0, o_ready}, 128'd0);
    tick();
    check("bp_valid2", {124'd0, o_valid}, 128'hA);
    check("bp_ready2", {127'd0, o_ready}, 128'd0);
    i_ready = 4'b1111;
    #1;
    check("bp_release_ready", {127'd0, o_ready}, 128'd1);
    tick();
    i_valid = 1'b0;
    check("bp_second_valid", {124'd0, o_valid}, 128'h3);
    check("bp_second_data", o_data_bus, 128'h00000000_00000000_CCCCCCCC_CCCCCCCC);
    tick();
    check("bp_clear", {124'd0, o_valid}, 128'd0);

    // 5. Enable gating, then a zero-command word
`ifdef DISTRIBUTE_1XN_PIPE_STALL_CNT_EN
    cnt_base = o_stall_cnt;
`endif
    i_en       = 1'b0;
    i_valid    = 1'b1;
    i_cmd      = 4'b1111;
    i_data_bus = 32'hDDDDDDDD;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("en_ready", {127'd0, o_ready}, 128'd0);
      tick();
      check("en_valid", {124'd0, o_valid}, 128'd0);
    end
    i_en  = 1'b1;
    i_cmd = 4'b0000;
    #1;
    check("zc_ready", {127'd0, o_ready}, 128'd1);
    tick();
    i_valid = 1'b0;
    check("zc_valid", {124'd0, o_valid}, 128'd0);
    check("zc_data", o_data_bus, 128'd0);
`ifdef DISTRIBUTE_1XN_PIPE_STALL_CNT_EN
    check("stall_cnt", {112'd0, 16'(o_stall_cnt - cnt_base)}, 128'd3);
`endif

    // 6. Reset mid-operation
    i_valid    = 1'b1;
    i_cmd      = 4'b0011;
    i_data_bus = 32'hEEEEEEEE;
    i_ready    = 4'b0000;
    tick();
    i_valid = 1'b0;
    check("mr_valid", {124'd0, o_valid}, 128'h3);
    check("mr_data", o_data_bus, 128'h00000000_00000000_EEEEEEEE_EEEEEEEE);
    rst = 1'b1;
    #1;
    check("mr_ready", {127'd0, o_ready}, 128'd0);
    tick();
    rst = 1'b0;
    check("mr_rst_valid", {124'd0, o_valid}, 128'd0);
    check("mr_rst_data", o_data_bus, 128'd0);
`ifdef DISTRIBUTE_1XN_PIPE_STALL_CNT_EN
    check("mr_stall_cnt", {112'd0, o_stall_cnt}, 128'd0);
`endif
    i_ready = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("mr_after_valid", {124'd0, o_valid}, 128'd0);
      check("mr_after_data", o_data_bus, 128'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
